// File: rtl/icache_refill_writer.sv
// -----------------------------------------------------------------------------
// icache_refill_writer
//
// Line-refill controller on the write side of the instruction cache's
// single-port BRAM arrays. A fetch miss triggers one burst read of the missing
// line; each returned word is written into the data BRAM. After the burst, the
// tag BRAM entry is written with {valid, tag}, and refill_done pulses so fetch
// can replay the access.
//
// Optional feature macro: ICACHE_REFILL_CRIT_WORD_EN
//   defined   -> the critical (missed) word is forwarded combinationally on
//                crit_valid/crit_data as it arrives during the burst.
//   undefined -> crit_valid/crit_data are tied to 0 and no forwarding logic
//                exists.
//
// Ports
//   clka, rstn            clock, asynchronous active-low reset
//   miss_valid/addr/ready miss request handshake (ready only in IDLE)
//   rd_req/addr/ready     burst read request to memory (line aligned)
//   ret_valid/last/data   returned beats; ret_ready only in RECV
//   data_wea/addra/dina   data BRAM write port, address {index, word}
//   tag_wea/addra/dina    tag BRAM write port, data {valid, tag}
//   refill_done/err       one-cycle completion pulse and burst-length error
//   crit_valid/data       forwarded critical word
// -----------------------------------------------------------------------------
module icache_refill_writer #(
  parameter int LINE_WORDS  = 4,
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 20
) (
  input  logic                                     clka,
  input  logic                                     rstn,
  input  logic                                     miss_valid,
  input  logic [31:0]                              miss_addr,
  output logic                                     miss_ready,
  output logic                                     rd_req,
  output logic [31:0]                              rd_addr,
  input  logic                                     rd_ready,
  input  logic                                     ret_valid,
  input  logic                                     ret_last,
  input  logic [31:0]                              ret_data,
  output logic                                     ret_ready,
  output logic                                     data_wea,
  output logic [INDEX_WIDTH+$clog2(LINE_WORDS)-1:0] data_addra,
  output logic [31:0]                              data_dina,
  output logic                                     tag_wea,
  output logic [INDEX_WIDTH-1:0]                   tag_addra,
  output logic [TAG_WIDTH:0]                       tag_dina,
  output logic                                     refill_done,
  output logic                                     refill_err,
  output logic                                     crit_valid,
  output logic [31:0]                              crit_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int LOW_W = OFF_W + 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RECV = 3'd2,
    S_TAGW = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                         r_state;
  logic [TAG_WIDTH-1:0]           r_tag;
  logic [INDEX_WIDTH-1:0]         r_index;
  logic [OFF_W-1:0]               r_cnt;
  logic                           r_wrap;   // counter already passed the last word
  logic                           r_err;
  logic                           r_miss_ready;
  logic                           r_rd_req;
  logic [31:0]                    r_rd_addr;
  logic                           r_ret_ready;
  logic                           r_data_wea;
  logic [INDEX_WIDTH+OFF_W-1:0]   r_data_addra;
  logic [31:0]                    r_data_dina;
  logic                           r_tag_wea;
  logic [INDEX_WIDTH-1:0]         r_tag_addra;
  logic [TAG_WIDTH:0]             r_tag_dina;
  logic                           r_refill_done;
  logic                           r_refill_err;

  logic w_beat;
  logic w_beat_err;
  logic w_err_next;

  // A beat only counts while receiving; ret_valid is ignored elsewhere.
  assign w_beat     = (r_state == S_RECV) && ret_valid;
  // Error: a beat after the counter wrapped, or last beat on the wrong word.
  assign w_beat_err = w_beat && (r_wrap || (ret_last && (r_cnt != LAST_BEAT)));
  assign w_err_next = r_err | w_beat_err;

`ifdef ICACHE_REFILL_CRIT_WORD_EN
  logic [OFF_W-1:0] r_off;
  logic             w_crit_hit;
  logic             w_unused_bits;

  assign w_crit_hit    = w_beat && !r_wrap && (r_cnt == r_off);
  assign crit_valid    = w_crit_hit;
  assign crit_data     = w_crit_hit ? ret_data : 32'h0000_0000;
  assign w_unused_bits = ^miss_addr[1:0];

  // Latch the word offset of the missed fetch for critical-word forwarding.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_off <= '0;
    end else if ((r_state == S_IDLE) && miss_valid && r_miss_ready) begin
      r_off <= miss_addr[2 +: OFF_W];
    end
  end
`else
  logic w_unused_bits;

  assign crit_valid    = 1'b0;
  assign crit_data     = 32'h0000_0000;
  assign w_unused_bits = ^miss_addr[LOW_W-1:0];
`endif

  // Refill FSM with all outputs registered; write strobes default low each cycle.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_tag         <= '0;
      r_index       <= '0;
      r_cnt         <= '0;
      r_wrap        <= 1'b0;
      r_err         <= 1'b0;
      r_miss_ready  <= 1'b0;
      r_rd_req      <= 1'b0;
      r_rd_addr     <= 32'h0000_0000;
      r_ret_ready   <= 1'b0;
      r_data_wea    <= 1'b0;
      r_data_addra  <= '0;
      r_data_dina   <= 32'h0000_0000;
      r_tag_wea     <= 1'b0;
      r_tag_addra   <= '0;
      r_tag_dina    <= '0;
      r_refill_done <= 1'b0;
      r_refill_err  <= 1'b0;
    end else begin
      r_data_wea    <= 1'b0;
      r_data_addra  <= '0;
      r_data_dina   <= 32'h0000_0000;
      r_tag_wea     <= 1'b0;
      r_tag_addra   <= '0;
      r_tag_dina    <= '0;
      r_refill_done <= 1'b0;
      r_refill_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_valid && r_miss_ready) begin
            r_tag        <= miss_addr[31 -: TAG_WIDTH];
            r_index      <= miss_addr[LOW_W +: INDEX_WIDTH];
            r_rd_addr    <= {miss_addr[31:LOW_W], {LOW_W{1'b0}}};
            r_rd_req     <= 1'b1;
            r_miss_ready <= 1'b0;
            r_state      <= S_REQ;
          end else begin
            // Also raises miss_ready on the first cycle after reset release.
            r_miss_ready <= 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ready) begin
            r_rd_req    <= 1'b0;
            r_rd_addr   <= 32'h0000_0000;
            r_cnt       <= '0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
            r_ret_ready <= 1'b1;
            r_state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_beat) begin
            // Beats past the end of the line are dropped, not written.
            if (!r_wrap) begin
              r_data_wea   <= 1'b1;
              r_data_addra <= {r_index, r_cnt};
              r_data_dina  <= ret_data;
            end
            if (r_cnt == LAST_BEAT) begin
              r_wrap <= 1'b1;
            end
            r_cnt <= r_cnt + OFF_W'(1);
            r_err <= w_err_next;
            if (ret_last) begin
              // Tag write shares the cycle with the final data write; a bad
              // burst never marks the line valid.
              r_ret_ready <= 1'b0;
              r_tag_wea   <= ~w_err_next;
              r_tag_addra <= r_index;
              r_tag_dina  <= {1'b1, r_tag};
              r_state     <= S_TAGW;
            end
          end
        end
        S_TAGW: begin
          r_refill_done <= 1'b1;
          r_refill_err  <= r_err;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          r_err        <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_miss_ready <= 1'b0;
          r_rd_req     <= 1'b0;
          r_ret_ready  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign miss_ready  = r_miss_ready;
  assign rd_req      = r_rd_req;
  assign rd_addr     = r_rd_addr;
  assign ret_ready   = r_ret_ready;
  assign data_wea    = r_data_wea;
  assign data_addra  = r_data_addra;
  assign data_dina   = r_data_dina;
  assign tag_wea     = r_tag_wea;
  assign tag_addra   = r_tag_addra;
  assign tag_dina    = r_tag_dina;
  assign refill_done = r_refill_done;
  assign refill_err  = r_refill_err;

endmodule

// File: tb/tb_icache_refill_writer.sv
// Self-checking bench for icache_refill_writer: directed refills from the test
// plan followed by randomized refills, checked against a transaction-level model
// (expected write list, tag write count, done/err timing).
module tb_icache_refill_writer;

  localparam int LW = 4;
  localparam int IW = 8;
  localparam int TW = 20;
  localparam int OW = $clog2(LW);
  localparam int AW = IW + OW;
`ifdef ICACHE_REFILL_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic          clka = 1'b0;
  logic          rstn;
  logic          miss_valid;
  logic [31:0]   miss_addr;
  logic          miss_ready;
  logic          rd_req;
  logic [31:0]   rd_addr;
  logic          rd_ready;
  logic          ret_valid;
  logic          ret_last;
  logic [31:0]   ret_data;
  logic          ret_ready;
  logic          data_wea;
  logic [AW-1:0] data_addra;
  logic [31:0]   data_dina;
  logic          tag_wea;
  logic [IW-1:0] tag_addra;
  logic [TW:0]   tag_dina;
  logic          refill_done;
  logic          refill_err;
  logic          crit_valid;
  logic [31:0]   crit_data;

  always #5 clka = ~clka;

  icache_refill_writer #(.LINE_WORDS(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clka(clka), .rstn(rstn),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data), .ret_ready(ret_ready),
    .data_wea(data_wea), .data_addra(data_addra), .data_dina(data_dina),
    .tag_wea(tag_wea), .tag_addra(tag_addra), .tag_dina(tag_dina),
    .refill_done(refill_done), .refill_err(refill_err),
    .crit_valid(crit_valid), .crit_data(crit_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_tag_act = 0;
  int last_t3_cyc = 0;
  int last_acc_cyc = 0;

  typedef struct packed {
    logic [31:0]   c;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t act_wr[$];
  wr_t exp_wr[$];

  always @(posedge clka) cyc <= cyc + 1;

  // Record every data write and count tag writes as seen on the BRAM ports.
  always @(negedge clka) begin
    if (data_wea) act_wr.push_back('{c: cyc, a: data_addra, d: data_dina});
    if (tag_wea) n_tag_act <= n_tag_act + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic any_out();
    return |{miss_ready, rd_req, rd_addr, ret_ready, data_wea, data_addra, data_dina,
             tag_wea, tag_addra, tag_dina, refill_done, refill_err, crit_valid, crit_data};
  endfunction

  // One refill transaction, entered and left at a falling edge.
  // nbeats: beats sent (ret_last on the final one); a clean line has LW beats.
  // busy: present a second miss (busy_addr) during RECV and leave it pending.
  // rst_at: assert reset at the start of that beat (-1 = never).
  task automatic run_refill(input logic [31:0] addr, input int nbeats, input int stall,
                            input int gap, input bit busy, input logic [31:0] busy_addr,
                            input int rst_at);
    int          off;
    int          idx;
    logic [31:0] tagv;
    logic [31:0] line;
    bit          clean;
    bit          want_crit;
    int          k;
    int          tag0;
    int          n;
    logic [31:0] d;

    off   = int'((addr >> 2) % LW);
    idx   = int'((addr >> (2 + OW)) % (1 << IW));
    tagv  = addr >> (2 + OW + IW);
    line  = addr - (addr % (LW * 4));
    clean = (nbeats == LW);
    tag0  = n_tag_act;
    exp_wr.delete();
    act_wr.delete();

    miss_valid = 1'b1;
    miss_addr  = addr;
    k = 0;
    while (!miss_ready && k < 64) begin
      @(negedge clka);
      k++;
    end
    check("miss_accept", miss_ready, 1'b1);
    if (!miss_ready) begin
      miss_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;

    @(negedge clka);
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    check("rd_req_latency", rd_req, 1'b1);
    check("rd_addr", rd_addr, line);
    check("miss_ready_req", miss_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      rd_ready  = 1'b0;
      ret_valid = 1'($urandom_range(0, 1));
      ret_last  = 1'($urandom_range(0, 1));
      ret_data  = $urandom;
      @(negedge clka);
      check("rd_req_hold", rd_req, 1'b1);
      check("rd_addr_hold", rd_addr, line);
    end
    rd_ready  = 1'b1;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    @(negedge clka);
    rd_ready = 1'b0;
    check("rd_req_drop", rd_req, 1'b0);
    if (busy) begin
      miss_valid = 1'b1;
      miss_addr  = busy_addr;
    end

    for (int b = 0; b < nbeats; b++) begin
      if (b == rst_at) begin
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        check("pre_reset_write", data_wea, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("reset_async_zero", any_out(), 1'b0);
        repeat (2) begin
          @(negedge clka);
          check("reset_hold_zero", any_out(), 1'b0);
        end
        rstn = 1'b1;
        @(negedge clka);
        check("reset_release_ready", miss_ready, 1'b1);
        check("reset_no_tag_write", n_tag_act - tag0, 0);
        act_wr.delete();
        exp_wr.delete();
        return;
      end
      for (int g = 0; g < gap; g++) begin
        ret_valid = 1'b0;
        ret_last  = 1'($urandom_range(0, 1));
        ret_data  = $urandom;
        @(negedge clka);
        check("ret_ready_gap", ret_ready, 1'b1);
        if (busy) check("miss_ready_busy", miss_ready, 1'b0);
      end
      check("ret_ready", ret_ready, 1'b1);
      if (busy) check("miss_ready_busy", miss_ready, 1'b0);
      d         = $urandom;
      ret_valid = 1'b1;
      ret_data  = d;
      ret_last  = (b == nbeats - 1);
      #1;
      want_crit = CRIT && (b == off);
      check("crit_valid", crit_valid, want_crit);
      if (want_crit) check("crit_data", crit_data, d);
      if (b < LW) exp_wr.push_back('{c: cyc + 1, a: AW'(idx * LW + b), d: d});
      @(negedge clka);
    end

    // Cycle after the last beat: final data write plus tag write.
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    check("tag_wea", tag_wea, clean);
    if (clean) begin
      check("tag_addra", tag_addra, idx);
      check("tag_dina", tag_dina, {1'b1, tagv[TW-1:0]});
    end
    check("done_not_early", refill_done, 1'b0);
    @(negedge clka);
    check("refill_done", refill_done, 1'b1);
    check("refill_err", refill_err, !clean);
    check("miss_ready_done", miss_ready, 1'b0);
    @(negedge clka);
    check("refill_done_pulse", refill_done, 1'b0);
    check("refill_err_pulse", refill_err, 1'b0);
    check("miss_ready_back", miss_ready, 1'b1);
    last_t3_cyc = cyc;
    check("tag_write_count", n_tag_act - tag0, clean ? 1 : 0);
    check("data_write_count", act_wr.size(), exp_wr.size());
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check("data_write_cycle", act_wr[i].c, exp_wr[i].c);
      check("data_addra", act_wr[i].a, exp_wr[i].a);
      check("data_dina", act_wr[i].d, exp_wr[i].d);
    end
  endtask

  initial begin
    int t3;
    int nb;
    rstn       = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = 32'h0000_0000;
    rd_ready   = 1'b0;
    ret_valid  = 1'b0;
    ret_last   = 1'b0;
    ret_data   = 32'h0000_0000;

    repeat (3) @(negedge clka);
    check("reset_outputs_zero", any_out(), 1'b0);
    rstn = 1'b1;
    @(negedge clka);
    check("ready_after_reset", miss_ready, 1'b1);
    check("idle_quiet", {rd_req, ret_ready, data_wea, tag_wea, refill_done}, 5'b0);

    // Clean refill (offset word 2 also exercises critical-word forwarding).
    run_refill(32'h0000_1238, LW, 0, 0, 1'b0, 32'h0, -1);
    // Stalled request and gapped beats.
    run_refill(32'hABCD_E574, LW, 5, 2, 1'b0, 32'h0, -1);
    // Short burst.
    run_refill(32'h1234_5600, 2, 1, 0, 1'b0, 32'h0, -1);
    // Long burst: extra beats dropped.
    run_refill(32'h0F0F_0F0C, 6, 0, 1, 1'b0, 32'h0, -1);
    // Reset mid-burst, then a clean refill.
    run_refill(32'h5555_5554, LW, 2, 0, 1'b0, 32'h0, 2);
    run_refill(32'h5555_5554, LW, 0, 0, 1'b0, 32'h0, -1);
    // Miss while busy: accepted in the cycle after DONE.
    run_refill(32'h0000_2004, LW, 1, 1, 1'b1, 32'hCAFE_0A48, -1);
    t3 = last_t3_cyc;
    run_refill(32'hCAFE_0A48, LW, 0, 0, 1'b0, 32'h0, -1);
    check("busy_accept_cycle", last_acc_cyc, t3);

    for (int r = 0; r < 25; r++) begin
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : LW;
      run_refill($urandom, nb, $urandom_range(0, 3), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), $urandom, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_refill_writer.md
# icache_refill_writer

Line-refill controller for the instruction cache; it is the write side of the ICache's single-port BRAM arrays. On a fetch miss it issues one burst read for the missing line and writes each returned word into the data BRAM. It then writes the tag and valid bit into the tag BRAM and pulses `refill_done` so the fetch stage can replay the access.

## Interface
- `LINE_WORDS`, 4: 32-bit words per cache line; must be a power of two ≥2.
- `INDEX_WIDTH`, 8: set-index bits; the tag BRAM depth is 2^INDEX_WIDTH.
- `TAG_WIDTH`, 20: tag bits. Requirement: TAG_WIDTH + INDEX_WIDTH + log2(LINE_WORDS) + 2 = 32.
- `clka`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `miss_valid`  in  1  a miss request is present.
- `miss_addr`  in  32  byte address of the missed fetch.
- `miss_ready`  out  1  the block can accept a miss; high only in IDLE.
- `rd_req`  out  1  burst read request to memory.
- `rd_addr`  out  32  line-aligned burst address (low log2(LINE_WORDS)+2 bits are zero).
- `rd_ready`  in  1  memory accepted `rd_req`.
- `ret_valid`  in  1  a returned data beat is present.
- `ret_last`  in  1  this beat is the final beat of the burst.
- `ret_data`  in  32  returned word.
- `ret_ready`  out  1  the block can accept a beat; high only in RECV.
- `data_wea`  out  1  data BRAM write enable.
- `data_addra`  out  INDEX_WIDTH+log2(LINE_WORDS)  data BRAM address, {index, word}.
- `data_dina`  out  32  data BRAM write data.
- `tag_wea`  out  1  tag BRAM write enable.
- `tag_addra`  out  INDEX_WIDTH  tag BRAM address.
- `tag_dina`  out  TAG_WIDTH+1  tag BRAM write data, {valid, tag}.
- `refill_done`  out  1  one-cycle pulse when the refill completes.
- `refill_err`  out  1  one-cycle pulse, coincident with `refill_done`, when the beat count was wrong.
- `crit_valid`, `crit_data`  out  1 / 32  forwarded critical word (see Configuration).

## Operation
- **States.** The FSM has five states: IDLE, REQ, RECV, TAGW, DONE.
- **IDLE.** When `miss_valid && miss_ready`, the block latches tag, index and word offset from `miss_addr` and moves to REQ.
- **REQ.** `rd_req`=1 and `rd_addr` = {tag, index, 0} are held stable until a cycle with `rd_ready`=1. The block then moves to RECV and clears the beat counter.
- **RECV.** Each beat with `ret_valid` is written to the data array.
  - The write goes to `data_addra` = {index, beat counter}.
  - The beat counter is log2(LINE_WORDS) bits wide and increments per beat.
  - When `ret_last` arrives, the block moves to TAGW.
- **Short or long burst.** If `ret_last` arrives on a beat other than number LINE_WORDS-1, or a beat arrives after the counter has wrapped, an error flag is set. Beats past LINE_WORDS-1 are not written to the data array.
- **TAGW.** On a clean burst, `tag_wea`=1 with `tag_dina` = {1'b1, tag}. If the error flag is set, `tag_wea`=0, so the line stays as previously stored and is never marked valid with partial data.
- **DONE.** `refill_done`=1 for one cycle, and `refill_err` equals the error flag. The next state is IDLE.
- **Outside RECV.** `ret_valid` is ignored.
- **`miss_valid` while busy.** It has no effect; the request stays pending until `miss_ready` returns high.

## Timing
- **Reset values.** All outputs are 0 during and after reset, and the state is IDLE. `miss_ready` becomes 1 in the first cycle after reset release.
- **Reset mid-operation.** Write enables drop immediately (asynchronously), the FSM returns to IDLE, and no tag write occurs.
- **Write outputs are registered.**
  - A beat accepted in cycle t produces `data_wea`, `data_addra` and `data_dina` in cycle t+1.
  - A last beat in cycle t gives: data write in t+1, together with TAGW and the tag write; `refill_done` in t+2; `miss_ready`=1 in t+3.
- **Request latency.** A miss accepted in cycle c gives `rd_req`=1 from cycle c+1.
- **Back-to-back beats.** Beats on consecutive cycles are sustained at one beat per cycle.

## Configuration
- **`ICACHE_REFILL_CRIT_WORD_EN` defined.** In RECV, when the beat counter equals the latched word offset and `ret_valid`=1, the block asserts `crit_valid`=1 for one cycle, combinationally in that cycle, with `crit_data` = `ret_data`. This lets fetch resume before the refill finishes. Forwarding happens even if the burst later errors.
- **Macro not defined.** `crit_valid` and `crit_data` are constant 0. No forwarding logic is built.

## Test plan
- **Clean refill.** Miss at 0x0000_1238, `rd_ready` in the first REQ cycle, 4 back-to-back beats A0..A3 with `ret_last` on beat 3 → `rd_addr`=0x0000_1230. Data writes go to {0x23,0..3} with A0..A3. Tag write to `tag_addra`=0x23 with `tag_dina`={1,0x00001}. `refill_done`=1 and `refill_err`=0 two cycles after the last beat.
- **Stalled request and gapped beats.** Hold `rd_ready`=0 for 5 cycles, and insert 2 idle cycles between beats → `rd_req` and `rd_addr` stay stable throughout. There are exactly 4 `data_wea` pulses at the correct addresses.
- **Short burst.** `ret_last` on beat 1 → exactly 2 data writes, `tag_wea` never asserted, and `refill_done`=1 with `refill_err`=1.
- **Reset mid-burst.** Drop `rstn` after 2 beats → all outputs 0 immediately, no tag write. After release `miss_ready`=1, and a new miss refills correctly.
- **Critical-word forwarding.** With the macro defined, miss at offset word 2 → `crit_valid`=1 exactly in the cycle beat 2 arrives, with `crit_data` equal to that beat's data. With the macro undefined, `crit_valid` stays 0.
- **Miss while busy.** Assert `miss_valid` with a different address during RECV → it is ignored (`miss_ready`=0). It is accepted the cycle after the DONE cycle, and `rd_req` follows one cycle later.
